// File: rtl/jk_state_register_pkg.sv
// Shared JK encodings, default sizing and the per-bit JK next-state helper.
package jk_state_register_pkg;

    // {j,k} encodings
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int unsigned DEF_N           = 2;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_STALL_LIMIT = 4;

    function automatic logic jk_next(input logic q_cur, input logic j_in, input logic k_in);
        logic q_nxt;
        case ({j_in, k_in})
            JK_HOLD: q_nxt = q_cur;
            JK_RST:  q_nxt = 1'b0;
            JK_SET:  q_nxt = 1'b1;
            JK_TGL:  q_nxt = ~q_cur;
            default: q_nxt = q_cur;
        endcase
        return q_nxt;
    endfunction

endpackage

// File: rtl/jk_state_register_jk_ff_bit.sv
// Single JK flip-flop with clock enable and synchronous parallel-load bit.
module jk_ff_bit
    import jk_state_register_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  logic load_bit,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_nxt_c
);

    logic q_q;
    logic q_d;

    // load beats enable; otherwise hold
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_bit;
        end else if (en) begin
            q_d = jk_next(q_q, j, k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign q_nxt_c = q_d;

endmodule

// File: rtl/jk_state_register.sv
// Bank of JK flip-flops with load/enable, a saturating transition counter
// and a sticky lock-up (stall) detector.
module jk_state_register
    import jk_state_register_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [N-1:0]     load_val,
    input  logic [N-1:0]     j,
    input  logic [N-1:0]     k,
    output logic [N-1:0]     q,
    output logic [N-1:0]     q_n,
    output logic             changed,
    output logic [CNT_W-1:0] trans_cnt,
    output logic             stall
);

    localparam int unsigned      SC_W      = $clog2(STALL_LIMIT + 1);
    localparam logic [SC_W-1:0]  STALL_LIM = SC_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [N-1:0]     q_nxt;
    logic             diff;

    logic             changed_q,   changed_d;
    logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d;
    logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic             stall_q,     stall_d;

    for (genvar i = 0; i < N; i++) begin : g_bit
        jk_ff_bit u_bit (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .load     (load),
            .load_bit (load_val[i]),
            .j        (j[i]),
            .k        (k[i]),
            .q        (q[i]),
            .q_nxt_c  (q_nxt[i])
        );
    end

    assign diff = (q_nxt != q);

    // Progress tracking: change pulse, saturating count, stall detection
    always_comb begin
        changed_d   = diff;
        trans_cnt_d = trans_cnt_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;

        if (diff && (trans_cnt_q != CNT_MAX)) begin
            trans_cnt_d = trans_cnt_q + CNT_W'(1);
        end

        if (load) begin
            stall_cnt_d = '0;
            stall_d     = 1'b0;
        end else if (diff) begin
            stall_cnt_d = '0;
        end else if (en && (stall_cnt_q != STALL_LIM)) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
        end

        if (!load && (stall_cnt_d == STALL_LIM)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q   <= 1'b0;
            trans_cnt_q <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            changed_q   <= changed_d;
            trans_cnt_q <= trans_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign q_n       = ~q;
    assign changed   = changed_q;
    assign trans_cnt = trans_cnt_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_jk_state_register.sv
// Directed scoreboard bench for jk_state_register (default and CNT_W=3 instances).
module tb_jk_state_register;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [1:0] load_val;
    logic [1:0] j;
    logic [1:0] k;

    logic [1:0] q,   q_n;
    logic       changed, stall;
    logic [7:0] trans_cnt;

    logic [1:0] q_s, q_n_s;
    logic       changed_s, stall_s;
    logic [2:0] trans_cnt_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] q;
        logic       changed;
        logic [7:0] cnt;
        logic [2:0] cnt_s;
        logic       stall;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic [1:0] m_q;
    logic       m_changed;
    logic [7:0] m_cnt;
    logic [2:0] m_cnt_s;
    int         m_sc;
    logic       m_stall;

    jk_state_register dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .j(j), .k(k), .q(q), .q_n(q_n), .changed(changed),
        .trans_cnt(trans_cnt), .stall(stall)
    );

    jk_state_register #(.N(2), .CNT_W(3), .STALL_LIMIT(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .j(j), .k(k), .q(q_s), .q_n(q_n_s), .changed(changed_s),
        .trans_cnt(trans_cnt_s), .stall(stall_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Excitation logic of the upstream stage: Ja=B, Ka=0, Jb=A, Kb=A&B
    task automatic excite(input logic [1:0] s, output logic [1:0] jj, output logic [1:0] kk);
        jj = {s[0], s[1]};
        kk = {1'b0, s[1] & s[0]};
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [1:0] eqn;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e   = sb.pop_front();
        eqn = ~e.q;
        chk("q",         32'(q),           32'(e.q));
        chk("q_n",       32'(q_n),         32'(eqn));
        chk("changed",   32'(changed),     32'(e.changed));
        chk("trans_cnt", 32'(trans_cnt),   32'(e.cnt));
        chk("stall",     32'(stall),       32'(e.stall));
        chk("q_s",       32'(q_s),         32'(e.q));
        chk("cnt_s",     32'(trans_cnt_s), 32'(e.cnt_s));
    endtask

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [1:0] lv, input logic [1:0] jj, input logic [1:0] kk);
        logic [1:0] nq;
        exp_t       x;
        rst = r; en = e; load = l; load_val = lv; j = jj; k = kk;
        if (r) begin
            m_q = 2'b00; m_changed = 1'b0; m_cnt = 8'd0; m_cnt_s = 3'd0;
            m_sc = 0; m_stall = 1'b0;
        end else begin
            if (l)      nq = lv;
            else if (e) nq = (jj & ~m_q) | (~kk & m_q);
            else        nq = m_q;
            m_changed = (nq != m_q);
            if (m_changed) begin
                if (m_cnt   != 8'hff) m_cnt   = m_cnt + 8'd1;
                if (m_cnt_s != 3'd7)  m_cnt_s = m_cnt_s + 3'd1;
            end
            if (l) begin
                m_sc = 0; m_stall = 1'b0;
            end else if (m_changed) begin
                m_sc = 0;
            end else if (e && m_sc < 4) begin
                m_sc++;
            end
            if (!l && m_sc == 4) m_stall = 1'b1;
            m_q = nq;
        end
        x.q = m_q; x.changed = m_changed; x.cnt = m_cnt; x.cnt_s = m_cnt_s; x.stall = m_stall;
        sb.push_back(x);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic loop_step();
        logic [1:0] jj, kk;
        excite(m_q, jj, kk);
        step(1'b0, 1'b1, 1'b0, 2'b00, jj, kk);
    endtask

    initial begin
        logic [1:0] cl_seq [6];
        cl_seq[0] = 2'b11; cl_seq[1] = 2'b10; cl_seq[2] = 2'b11;
        cl_seq[3] = 2'b10; cl_seq[4] = 2'b11; cl_seq[5] = 2'b10;

        m_q = 2'b00; m_changed = 1'b0; m_cnt = 8'd0; m_cnt_s = 3'd0; m_sc = 0; m_stall = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        chk("rst_q",   32'(q),   32'h0);
        chk("rst_q_n", 32'(q_n), 32'h3);

        // per-bit JK table
        step(1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 2'b00); chk("jk_set",  32'(q), 32'h3);
        step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11); chk("jk_rst",  32'(q), 32'h0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11); chk("jk_tgl",  32'(q), 32'h3);
        step(1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01); chk("jk_mix",  32'(q), 32'h2);
        chk("jk_cnt", 32'(trans_cnt), 32'd4);

        // closed loop from 01
        step(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) begin
            loop_step();
            chk("cl_q", 32'(q), 32'(cl_seq[i]));
            chk("cl_changed", 32'(changed), 32'd1);
        end
        chk("cl_stall", 32'(stall), 32'd0);

        // dead state 00
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) loop_step();
        chk("dead_stall3", 32'(stall), 32'd0);
        loop_step();
        chk("dead_stall4", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        chk("dead_hold_stall", 32'(stall), 32'd1);
        step(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
        chk("dead_load_clr", 32'(stall), 32'd0);

        // priority and gating
        step(1'b0, 1'b1, 1'b1, 2'b10, 2'b11, 2'b11);
        chk("prio_load", 32'(q), 32'h2);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11);
        chk("prio_hold", 32'(q), 32'h2);
        chk("prio_hold_chg", 32'(changed), 32'd0);
        step(1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11);
        chk("prio_rst", 32'(q), 32'h0);

        // counter saturation on the CNT_W=3 instance
        step(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++) loop_step();
        chk("sat_cnt_s", 32'(trans_cnt_s), 32'd7);
        chk("sat_cnt",   32'(trans_cnt),   32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
